// File: rtl/hazard_ctrl_if.sv
// Purpose: bundles the Decode/Execute/Memory/Writeback hazard inputs and the
//          forwarding, stall, flush and perf outputs of the hazard unit.
// Latency: none (wiring only). Backpressure: none; stalls are carried as signals.
// Ports:   master = pipeline side (drives register ids/enables, receives controls)
//          slave  = hazard_ctrl (receives register ids/enables, drives controls)
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 16
);
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [REG_AW-1:0] rd_e;
    logic              resultsrc_e;
    logic              mc_start_e;
    logic              pcsrc_e;
    logic [REG_AW-1:0] rd_m;
    logic              regwrite_m;
    logic [REG_AW-1:0] rd_w;
    logic              regwrite_w;

    logic [1:0]        forward_a_e;
    logic [1:0]        forward_b_e;
    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              flush_d;
    logic              flush_e;
    logic              bubble_m;
    logic              mc_busy;
    logic              mc_done;
    logic [PERF_W-1:0] perf_stall_cnt;
    logic [PERF_W-1:0] perf_flush_cnt;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, resultsrc_e, mc_start_e, pcsrc_e,
               rd_m, regwrite_m, rd_w, regwrite_w,
        input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, flush_d, flush_e,
               bubble_m, mc_busy, mc_done, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, resultsrc_e, mc_start_e, pcsrc_e,
               rd_m, regwrite_m, rd_w, regwrite_w,
        output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, flush_d, flush_e,
               bubble_m, mc_busy, mc_done, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: pipeline hazard unit - forwarding selects, load-use stall, branch flush,
//          multicycle-execute interlock (IDLE/BUSY/DONE FSM) and optional perf counters.
// Latency: forwarding/stall/flush are combinational; multicycle op stalls MC_LAT-1 cycles.
// Backpressure: drives stall_f/d/e and bubble_m; never stalled itself.
// Ports:   clk, rst (async active-low), hif (hazard_ctrl_if.slave).
// Option:  define HAZARD_PERF_EN to build the saturating stall/flush counters;
//          otherwise perf_stall_cnt/perf_flush_cnt are tied to zero.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int PERF_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hif
);

    generate
        if (MC_LAT < 2) begin : g_bad_mc_lat
            $error("hazard_ctrl: MC_LAT must be >= 2");
        end
    endgenerate

    localparam int CNT_W = ($clog2(MC_LAT) > 0) ? $clog2(MC_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    mc_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Forwarding select for one Execute operand; M beats W, x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              regwrite_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              regwrite_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (regwrite_m && (rd_m == rs))      sel = 2'b10;
            else if (regwrite_w && (rd_w == rs)) sel = 2'b01;
        end
        return sel;
    endfunction

    // Raw (reset-ungated) control terms; the port outputs are masked by rst below.
    logic       mc_stall;
    logic       load_use;
    logic       branch;
    logic       stall_raw;
    logic       flush_d_raw;
    logic       flush_e_raw;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    always_comb begin
        fwd_a = fwd_sel(hif.rs1_e, hif.rd_m, hif.regwrite_m, hif.rd_w, hif.regwrite_w);
        fwd_b = fwd_sel(hif.rs2_e, hif.rd_m, hif.regwrite_m, hif.rd_w, hif.regwrite_w);

        // Interlock is live from the cycle the op is first seen in E (IDLE) through BUSY.
        mc_stall = ((state_q == IDLE) && hif.mc_start_e) || (state_q == BUSY);

        // A taken branch discards the younger Decode instruction, so load-use is moot.
        branch   = hif.pcsrc_e && !mc_stall;
        load_use = hif.resultsrc_e && (hif.rd_e != '0)
                && ((hif.rd_e == hif.rs1_d) || (hif.rd_e == hif.rs2_d))
                && !hif.pcsrc_e && !mc_stall;

        stall_raw   = mc_stall || load_use;
        flush_d_raw = branch;
        flush_e_raw = branch || load_use;
    end

    // Multicycle FSM: load MC_LAT-2, leave BUSY when the count reaches 1 so the
    // stall window covers exactly MC_LAT-1 cycles, then one DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hif.mc_start_e) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (MC_LAT == 2) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // The finishing op is still in E here, so mc_start_e is not a new request.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output reads zero while reset is held, including the combinational ones.
    assign hif.forward_a_e = rst ? fwd_a : 2'b00;
    assign hif.forward_b_e = rst ? fwd_b : 2'b00;
    assign hif.stall_f     = rst && stall_raw;
    assign hif.stall_d     = rst && stall_raw;
    assign hif.stall_e     = rst && mc_stall;
    assign hif.flush_d     = rst && flush_d_raw;
    assign hif.flush_e     = rst && flush_e_raw;
    assign hif.bubble_m    = rst && mc_stall;
    assign hif.mc_busy     = rst && mc_stall;
    assign hif.mc_done     = rst && (state_q == DONE);

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

    // Saturating counters: hold at all-ones rather than wrap.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_raw && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + PERF_W'(1);
        if ((flush_d_raw || flush_e_raw) && (perf_flush_q != '1))
            perf_flush_d = perf_flush_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign hif.perf_stall_cnt = perf_stall_q;
    assign hif.perf_flush_cnt = perf_flush_q;
`else
    assign hif.perf_stall_cnt = {PERF_W{1'b0}};
    assign hif.perf_flush_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int MC_LAT = 4;
    localparam int PERF_W = 4;

`ifdef HAZARD_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    hazard_ctrl_if #(.REG_AW(REG_AW), .PERF_W(PERF_W)) hif ();

    hazard_ctrl #(
        .REG_AW (REG_AW),
        .MC_LAT (MC_LAT),
        .PERF_W (PERF_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        hif.rs1_d       = '0;
        hif.rs2_d       = '0;
        hif.rs1_e       = '0;
        hif.rs2_e       = '0;
        hif.rd_e        = '0;
        hif.resultsrc_e = 1'b0;
        hif.mc_start_e  = 1'b0;
        hif.pcsrc_e     = 1'b0;
        hif.rd_m        = '0;
        hif.regwrite_m  = 1'b0;
        hif.rd_w        = '0;
        hif.regwrite_w  = 1'b0;
    endtask

    // Checks every control output against one packed expectation.
    task automatic chk_ctrl(input string tag, input logic sf, input logic sd, input logic se,
                            input logic fd, input logic fe, input logic bm,
                            input logic busy, input logic done);
        chk({tag, ".stall_f"},  32'(hif.stall_f),  32'(sf));
        chk({tag, ".stall_d"},  32'(hif.stall_d),  32'(sd));
        chk({tag, ".stall_e"},  32'(hif.stall_e),  32'(se));
        chk({tag, ".flush_d"},  32'(hif.flush_d),  32'(fd));
        chk({tag, ".flush_e"},  32'(hif.flush_e),  32'(fe));
        chk({tag, ".bubble_m"}, 32'(hif.bubble_m), 32'(bm));
        chk({tag, ".mc_busy"},  32'(hif.mc_busy),  32'(busy));
        chk({tag, ".mc_done"},  32'(hif.mc_done),  32'(done));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        clr_inputs();
        // Hazard-looking inputs during reset must not leak to the outputs.
        hif.rs1_e      = 5'd5;
        hif.rd_m       = 5'd5;
        hif.regwrite_m = 1'b1;
        hif.mc_start_e = 1'b1;
        #1;
        chk("reset.fwd_a", 32'(hif.forward_a_e), 32'd0);
        chk_ctrl("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.perf_stall", 32'(hif.perf_stall_cnt), 32'd0);

        @(negedge clk);
        @(negedge clk);
        clr_inputs();
        rst = 1'b1;
        #1;
        chk_ctrl("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // 1. Forwarding priority and x0 exclusion.
        @(negedge clk);
        hif.rs1_e = 5'd5; hif.rs2_e = 5'd5;
        hif.rd_m = 5'd5;  hif.regwrite_m = 1'b1;
        hif.rd_w = 5'd5;  hif.regwrite_w = 1'b1;
        #1;
        chk("fwd.m_prio.a", 32'(hif.forward_a_e), 32'd2);
        chk("fwd.m_prio.b", 32'(hif.forward_b_e), 32'd2);
        hif.regwrite_m = 1'b0;
        #1;
        chk("fwd.w.a", 32'(hif.forward_a_e), 32'd1);
        hif.rs1_e = 5'd0;
        #1;
        chk("fwd.x0.a", 32'(hif.forward_a_e), 32'd0);
        chk("fwd.w.b",  32'(hif.forward_b_e), 32'd1);
        hif.rd_w = 5'd0; hif.rs2_e = 5'd0; hif.regwrite_w = 1'b1;
        #1;
        chk("fwd.x0_w.b", 32'(hif.forward_b_e), 32'd0);
        clr_inputs();

        // 2. Load-use, then no stall when the load targets x0.
        @(negedge clk);
        hif.resultsrc_e = 1'b1; hif.rd_e = 5'd7; hif.rs2_d = 5'd7;
        #1;
        chk_ctrl("lu", 1, 1, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        hif.resultsrc_e = 1'b0;
        #1;
        chk_ctrl("lu_gone", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        hif.resultsrc_e = 1'b1; hif.rd_e = 5'd0; hif.rs1_d = 5'd0; hif.rs2_d = 5'd0;
        #1;
        chk_ctrl("lu_x0", 0, 0, 0, 0, 0, 0, 0, 0);
        clr_inputs();

        // 3. Branch wins over a simultaneous load-use.
        @(negedge clk);
        hif.resultsrc_e = 1'b1; hif.rd_e = 5'd9; hif.rs1_d = 5'd9; hif.pcsrc_e = 1'b1;
        #1;
        chk_ctrl("br_lu", 0, 0, 0, 1, 1, 0, 0, 0);
        clr_inputs();

        // 4. Multicycle op (MC_LAT=4): stall cycles 0..2, done in 3, idle in 4.
        @(negedge clk);
        hif.mc_start_e = 1'b1;
        #1;
        chk_ctrl("mc.c0", 1, 1, 1, 0, 0, 1, 1, 0);
        @(negedge clk);
        hif.pcsrc_e = 1'b1;
        #1;
        chk_ctrl("mc.c1_br", 1, 1, 1, 0, 0, 1, 1, 0);
        @(negedge clk);
        hif.pcsrc_e = 1'b0;
        #1;
        chk_ctrl("mc.c2", 1, 1, 1, 0, 0, 1, 1, 0);
        @(negedge clk);
        hif.pcsrc_e = 1'b1;
        #1;
        chk_ctrl("mc.c3_done_br", 0, 0, 0, 1, 1, 0, 0, 1);
        @(negedge clk);
        clr_inputs();
        #1;
        chk_ctrl("mc.c4_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // 5. Reset asserted in cycle 1 of a multicycle op.
        @(negedge clk);
        hif.mc_start_e = 1'b1;
        #1;
        chk("rmo.c0.busy", 32'(hif.mc_busy), 32'd1);
        @(negedge clk);
        #1;
        chk("rmo.c1.busy", 32'(hif.mc_busy), 32'd1);
        rst = 1'b0;
        #1;
        chk_ctrl("rmo.in_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        hif.mc_start_e = 1'b0;
        #1;
        chk_ctrl("rmo.release", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk_ctrl("rmo.idle", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rmo.perf_stall", 32'(hif.perf_stall_cnt), 32'd0);

        // 6. Perf counters: 3 branch flushes, then 20 load-use cycles (PERF_W=4 saturates at 15).
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hif.pcsrc_e = 1'b1;
        end
        @(negedge clk);
        clr_inputs();
        #1;
        chk("perf.flush3", 32'(hif.perf_flush_cnt), PERF_ON ? 32'd3 : 32'd0);
        chk("perf.stall0", 32'(hif.perf_stall_cnt), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) begin
                #1;
                chk("perf.stall5", 32'(hif.perf_stall_cnt), PERF_ON ? 32'd5 : 32'd0);
            end
            hif.resultsrc_e = 1'b1; hif.rd_e = 5'd3; hif.rs1_d = 5'd3;
        end
        @(negedge clk);
        clr_inputs();
        #1;
        chk("perf.stall_sat", 32'(hif.perf_stall_cnt), PERF_ON ? 32'd15 : 32'd0);
        chk("perf.flush_sat", 32'(hif.perf_flush_cnt), PERF_ON ? 32'd15 : 32'd0);
        @(negedge clk);
        #1;
        chk("perf.stall_hold", 32'(hif.perf_stall_cnt), PERF_ON ? 32'd15 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised successor to the pipeline's forwarding/stall hazard unit.
- Adds load-use stall, branch flush and a multicycle-execute interlock driven by an internal FSM and latency counter.
- Drives forwarding selects into Execute and stall, flush and bubble controls into the Fetch, Decode, Execute and Memory pipeline registers.
- Instantiated once in the pipeline top.

Parameters:
- REG_AW, 5, register-address width; register 0 is hardwired zero and is never forwarded or interlocked.
- MC_LAT, 4, total Execute-stage cycles of a multicycle op; must be ≥2 (elaboration error otherwise).
- PERF_W, 16, width of the performance counters (see Optional Feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rs1_d  in  REG_AW  Decode source register 1.
- rs2_d  in  REG_AW  Decode source register 2.
- rs1_e  in  REG_AW  Execute source register 1.
- rs2_e  in  REG_AW  Execute source register 2.
- rd_e  in  REG_AW  Execute destination register.
- resultsrc_e  in  1  Execute instruction is a load.
- mc_start_e  in  1  Execute instruction is multicycle; held high while it sits in E.
- pcsrc_e  in  1  branch taken in Execute.
- rd_m  in  REG_AW  Memory destination register.
- regwrite_m  in  1  Memory register-write enable.
- rd_w  in  REG_AW  Writeback destination register.
- regwrite_w  in  1  Writeback register-write enable.
- forward_a_e  out  2  ALU operand A select: 00 register file, 01 ResultW, 10 ALU_ResultM.
- forward_b_e  out  2  ALU operand B select, same encoding.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold Fetch/Decode register.
- stall_e  out  1  hold Decode/Execute register.
- flush_d  out  1  clear Fetch/Decode register.
- flush_e  out  1  clear Decode/Execute register.
- bubble_m  out  1  clear Execute/Memory register.
- mc_busy  out  1  multicycle op stalling.
- mc_done  out  1  final multicycle cycle.
- perf_stall_cnt  out  PERF_W  stall-cycle counter.
- perf_flush_cnt  out  PERF_W  flush-event counter.

Behaviour:
- Reset: while rst=0, all outputs are 0, the FSM is in IDLE and the counter is 0. Assertion mid-operation aborts a multicycle op immediately.
- Forwarding, per operand (combinational), for rsX_e ≠ 0:
  - 10 if regwrite_m and rd_m == rsX_e;
  - else 01 if regwrite_w and rd_w == rsX_e;
  - else 00.
  - M has priority over W when both match.
- Load-use: resultsrc_e & rd_e ≠ 0 & (rd_e == rs1_d | rd_e == rs2_d) drives stall_f = stall_d = flush_e = 1 for that cycle.
- Branch: pcsrc_e drives flush_d = flush_e = 1 and suppresses the load-use stall (the younger instruction is discarded).
- Multicycle FSM, states IDLE, BUSY, DONE; cnt is log2(MC_LAT) bits.
  - IDLE & mc_start_e at cycle T: stall_f = stall_d = stall_e = bubble_m = mc_busy = 1 combinationally; load cnt = MC_LAT-2; next state BUSY. If MC_LAT = 2, next state is DONE instead.
  - BUSY: same stall outputs; cnt decrements; when cnt = 0 the next state is DONE (transition when cnt==1 or use count so that stalls cover T..T+MC_LAT-2).
  - DONE: stalls low, mc_done = 1 for one cycle, next state IDLE. mc_start_e is ignored in DONE because the same instruction is still in E.
  - Net effect: exactly MC_LAT-1 stall cycles, done at T+MC_LAT-1, IDLE at T+MC_LAT.
- Priority:
  - MC stall (IDLE-start or BUSY) overrides everything: pcsrc_e and load-use are ignored and flush_d = flush_e = 0.
  - In DONE, branch and load-use evaluate normally.
- mc_start_e while BUSY is ignored. Forwarding is unaffected by FSM state.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle stall_f = 1.
  - perf_flush_cnt increments each cycle flush_d | flush_e = 1.
  - Both counters saturate at 2^PERF_W-1 and are cleared by reset.
- Undefined: no counters are built, and both outputs are tied 0.

Test Plan:
1. Forwarding: rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> forward_a_e=10. Then regwrite_m=0 -> 01. Then rs1_e=0 -> 00.
2. Load-use: resultsrc_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1, flush_d=0 for one cycle. Repeat with rd_e=0 -> no stall.
3. Branch plus load-use in the same cycle: pcsrc_e=1, load-use condition true -> flush_d=flush_e=1, stall_f=0.
4. Multicycle, MC_LAT=4: mc_start_e held from cycle 0 -> stalls and bubble_m high in cycles 0–2, mc_done=1 in cycle 3, IDLE in cycle 4. With pcsrc_e=1 in cycle 1 -> no flush.
5. Reset mid-op: rst low in cycle 1 of a multicycle op -> all outputs 0 immediately. After release with mc_start_e=0 -> IDLE, no stall.
6. HAZARD_PERF_EN with PERF_W=4: 20 stall cycles -> perf_stall_cnt=15 (saturated). Macro undefined -> both counters read 0.
